fifo_sync_param: RTL and testbench
==================================

# fifo_sync_param

Parametrised single-clock FIFO: the next generation of the team's 16×8 buffer. It adds configurable width and depth, a fill-level count, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It sits between byte/word producers and consumers in the same clock domain, such as UART/SPI datapaths and RISC-V peripheral buffering.

## Interface
Parameters:
- WIDTH, 8: data word width in bits, ≥1.
- DEPTH, 16: number of entries. Must be a power of two, ≥2.
- AFULL_TH, DEPTH-2: almost_full asserts when count ≥ AFULL_TH. Legal range is 1..DEPTH.
- AEMPTY_TH, 2: almost_empty asserts when count ≤ AEMPTY_TH. Legal range is 0..DEPTH-1.

Derived: AW = $clog2(DEPTH).

Ports:
- CLK, in, 1: sole clock. All state changes on rising edge.
- RSTn, in, 1: asynchronous, active-low reset.
- write, in, 1: write request.
- read, in, 1: read request.
- flush, in, 1: synchronous clear of contents.
- clr_err, in, 1: synchronous clear of the sticky error flags.
- iData, in, WIDTH: write data.
- oData, out, WIDTH: read data (registered).
- count, out, AW+1: current occupancy, 0..DEPTH.
- full, out, 1: count == DEPTH.
- empty, out, 1: count == 0.
- almost_full, out, 1: count ≥ AFULL_TH.
- almost_empty, out, 1: count ≤ AEMPTY_TH.
- overflow, out, 1: sticky flag; a write was attempted while full.
- underflow, out, 1: sticky flag; a read was attempted while empty.

## Operation
- Pointers:
  - wp and rp are AW+1 bits wide. The low AW bits address the RAM; the MSB is the wrap bit.
  - count = wp − rp, taken modulo 2^(AW+1).
  - full is true when the MSBs differ and the low bits are equal. empty is true when wp == rp.
  - All status flags are combinational from the registered pointers and error regs. No flag depends on the current cycle's inputs.
- Write accept: wr_ok = write & ~full.
  - The write is decided on the pre-edge full value. It is not rescued by a simultaneous read.
  - On wr_ok: RAM[wp[AW-1:0]] ← iData, then wp ← wp+1.
- Read accept: rd_ok = read & ~empty.
  - On rd_ok: oData ← RAM[rp[AW-1:0]], then rp ← rp+1.
  - oData holds its value on all other cycles.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
  - When empty, the read is rejected and the write is accepted (no bypass).
  - When full, the write is rejected and the read is accepted.
- Errors:
  - write & full sets overflow. read & empty sets underflow.
  - Rejected requests change no other state.
  - clr_err clears both flags. If a new error occurs in the same cycle as clr_err, the set wins.
- flush:
  - Sets wp ← 0 and rp ← 0. Highest priority: write and read are ignored that cycle.
  - Error flags are not raised during flush.
  - oData and error flags are unchanged; RAM contents are don't-care.
- Reset (RSTn low, any time, including mid-transfer):
  - wp, rp, oData, overflow and underflow all clear to 0 immediately.
  - Resulting outputs: count=0, empty=1, full=0, almost_empty=1, almost_full=0 (given AFULL_TH ≥ 1).
  - RAM is not reset.

## Timing
- Write-to-visibility: data written at edge N can be read at edge N+1. empty deasserts after edge N.
- Read latency: 1 cycle. Read sampled at edge N puts the data on oData after edge N. oData is valid in cycle N+1.
- Flags and count update after the same edge that moves the pointers.
- Throughput: one write and one read per cycle, sustained.
- Wrap-around: the low pointer bits roll from DEPTH-1 to 0 and toggle the MSB. Pointers wrap freely modulo 2·DEPTH.

## Structure
- Shared header `fifo_defs`: the clog2 helper, default WIDTH and DEPTH, and the error-flag bit positions for register-map reuse.
- One sub-module, `fifo_ram`: a DEPTH×WIDTH array with one synchronous write port and one synchronous registered read port with a read-enable. It holds no reset logic.
- The top level holds the pointers, flag logic and error regs.

## Test plan
All scenarios use WIDTH=8, DEPTH=16, AFULL_TH=14, AEMPTY_TH=2.
- Reset then idle → count=0, empty=1, almost_empty=1, full=0, oData=0x00, errors=0.
- Write 0x00..0x0F → after 14th write almost_full=1; after 16th full=1, count=16. 17th write (0xAA) → overflow=1, count stays 16. Read 16 → oData sequence 0x00..0x0F, one cycle after each read.
- Read while empty → underflow=1, oData unchanged, rp unchanged. clr_err → underflow=0. clr_err with read-on-empty in the same cycle → underflow stays 1.
- Keep count at 8 with simultaneous write/read for 40 cycles (pointers wrap twice) → count constant 8, data in order, no errors.
- Full FIFO plus write & read in the same cycle → read accepted, write rejected, overflow=1, count=15. Empty FIFO plus write & read → write accepted, underflow=1, count=1.
- Count=5, then flush with write asserted → count=0, empty=1, no overflow. Assert RSTn low mid-burst → all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/fifo_sync_param_pkg.sv
// fifo_defs: shared FIFO defaults, clog2 helper and error-flag bit positions.
package fifo_defs;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;
    localparam int ERR_OVF   = 0;
    localparam int ERR_UNF   = 1;
    localparam int ERR_BITS  = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x WIDTH storage, synchronous write port and registered read port with enable.
module fifo_ram
    import fifo_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = clog2(DEF_DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with fill count, almost-full/empty thresholds,
// synchronous flush and sticky overflow/underflow flags.
module fifo_sync_param
    import fifo_defs::*;
#(
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int DEPTH     = DEF_DEPTH,
    parameter  int AFULL_TH  = DEPTH - 2,
    parameter  int AEMPTY_TH = 2,
    localparam int AW        = clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             write,
    input  logic             read,
    input  logic             flush,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] iData,
    output logic [WIDTH-1:0] oData,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    logic [AW:0]          wp, rp;
    logic [ERR_BITS-1:0]  err, err_set;
    logic                 wr_ok, rd_ok, rd_vld;
    logic [WIDTH-1:0]     ram_q;

    assign count        = wp - rp;
    assign empty        = wp == rp;
    assign full         = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign almost_full  = 32'(count) >= AFULL_TH;
    assign almost_empty = 32'(count) <= AEMPTY_TH;
    assign overflow     = err[ERR_OVF];
    assign underflow    = err[ERR_UNF];
    assign wr_ok        = write & ~full & ~flush;
    assign rd_ok        = read & ~empty & ~flush;

    always_comb begin
        err_set          = '0;
        err_set[ERR_OVF] = write & full & ~flush;
        err_set[ERR_UNF] = read & empty & ~flush;
    end

    // The RAM output register has no reset, so oData reads as zero until the first read lands.
    assign oData = rd_vld ? ram_q : '0;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wp     <= '0;
            rp     <= '0;
            err    <= '0;
            rd_vld <= 1'b0;
        end else begin
            wp     <= flush ? '0 : wp + (AW+1)'(wr_ok);
            rp     <= flush ? '0 : rp + (AW+1)'(rd_ok);
            err    <= (err & ~{ERR_BITS{clr_err}}) | err_set;
            rd_vld <= rd_vld | rd_ok;
        end
    end

    fifo_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk  (CLK),
        .we   (wr_ok),
        .waddr(wp[AW-1:0]),
        .wdata(iData),
        .re   (rd_ok),
        .raddr(rp[AW-1:0]),
        .rdata(ram_q)
    );

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed and random stimulus against a queue-based FIFO model,
// with a separate negedge monitor that scores oData and status against the model.
module tb_fifo_sync_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AFT   = 14;
    localparam int AET   = 2;

    logic             CLK = 0;
    logic             RSTn = 0;
    logic             write = 0, read = 0, flush = 0, clr_err = 0;
    logic [WIDTH-1:0] iData = 0;
    logic [WIDTH-1:0] oData;
    logic [4:0]       count;
    logic             full, empty, almost_full, almost_empty, overflow, underflow;

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_last = 0;
    bit               m_ovf = 0, m_unf = 0;

    fifo_sync_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFT), .AEMPTY_TH(AET)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .write(write), .read(read), .flush(flush),
        .clr_err(clr_err), .iData(iData), .oData(oData), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_status();
        int n;
        n = mq.size();
        chk("count", int'(count), n);
        chk("full", int'(full), int'(n == DEPTH));
        chk("empty", int'(empty), int'(n == 0));
        chk("almost_full", int'(almost_full), int'(n >= AFT));
        chk("almost_empty", int'(almost_empty), int'(n <= AET));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_unf));
    endtask

    // Monitor: read data appears the cycle after an accepted read, otherwise oData holds.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) m_last = exp_q.pop_front();
        chk("oData", int'(oData), int'(m_last));
        chk_status();
    end

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_last = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic step(input bit w, input bit r, input bit f, input bit c, input logic [WIDTH-1:0] d);
        bit wok, rok;
        write = w; read = r; flush = f; clr_err = c; iData = d;
        @(posedge CLK);
        wok = w && !f && mq.size() < DEPTH;
        rok = r && !f && mq.size() > 0;
        if (c) begin m_ovf = 0; m_unf = 0; end
        if (w && !f && !wok) m_ovf = 1;
        if (r && !f && !rok) m_unf = 1;
        if (f) mq.delete();
        if (rok) exp_q.push_back(mq.pop_front());
        if (wok) mq.push_back(d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        #2;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_oData", int'(oData), 0);
        #20 RSTn = 1;
        @(posedge CLK); #1;
        idle(2);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(i));
        step(1, 0, 0, 0, 8'hAA);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        idle(1);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 8'($urandom));
        for (int i = 0; i < 40; i++) step(1, 1, 0, 0, 8'($urandom));
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'($urandom));
        step(1, 1, 0, 0, 8'h55);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 8'h33);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'($urandom));
        step(1, 0, 1, 0, 8'h77);
        idle(1);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0, 8'($urandom));
        for (int i = 0; i < 10; i++) step(1, $urandom_range(0, 1) == 1, 0, 0, 8'($urandom));
        #2 RSTn = 0;
        model_reset();
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_full", int'(full), 0);
        chk("arst_aempty", int'(almost_empty), 1);
        chk("arst_afull", int'(almost_full), 0);
        chk("arst_oData", int'(oData), 0);
        chk("arst_err", int'({overflow, underflow}), 0);
        write = 0; read = 0;
        @(negedge CLK);
        RSTn = 1;
        @(posedge CLK); #1;
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 9) < 5, $urandom_range(0, 9) < 5,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0, 8'($urandom));
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
